// File: rtl/data_4.sv
// Two-stage transfer register: clk1 strobe loads datain into a, clk2 strobe copies a into b.
// Both strobes are synchronized and rising-edge detected on clk; a strobe already high at reset release is ignored.
module data_4 #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] datain,
   input  logic             clk1,
   input  logic             clk2,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b
);

   localparam int CW = $clog2(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] sync1_q, sync1_d;
   logic [SYNC_STAGES-1:0] sync2_q, sync2_d;
   logic                   hist1_q, hist1_d;
   logic                   hist2_q, hist2_d;
   logic                   armed1_q, armed1_d;
   logic                   armed2_q, armed2_d;
   logic [CW-1:0]          settle_q, settle_d;
   logic [WIDTH-1:0]       a_q, a_d;
   logic [WIDTH-1:0]       b_q, b_d;
   logic                   pulse1, pulse2;
   logic                   settled;

   // The synchronizer outputs only reflect real strobe samples once the chain has
   // refilled after reset; arming before that would accept a strobe held high across release.
   always_comb begin
      settled  = (settle_q == '0);
      settle_d = settled ? settle_q : settle_q - CW'(1);

      sync1_d  = {sync1_q[SYNC_STAGES-2:0], clk1};
      sync2_d  = {sync2_q[SYNC_STAGES-2:0], clk2};
      hist1_d  = sync1_q[SYNC_STAGES-1];
      hist2_d  = sync2_q[SYNC_STAGES-1];

      armed1_d = armed1_q | (settled & ~sync1_q[SYNC_STAGES-1]);
      armed2_d = armed2_q | (settled & ~sync2_q[SYNC_STAGES-1]);

      pulse1   = sync1_q[SYNC_STAGES-1] & ~hist1_q & armed1_q;
      pulse2   = sync2_q[SYNC_STAGES-1] & ~hist2_q & armed2_q;

      a_d      = pulse1 ? datain : a_q;
      b_d      = pulse2 ? a_q    : b_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         hist1_q  <= 1'b0;
         hist2_q  <= 1'b0;
         armed1_q <= 1'b0;
         armed2_q <= 1'b0;
         settle_q <= CW'(SYNC_STAGES);
         a_q      <= '0;
         b_q      <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         hist1_q  <= hist1_d;
         hist2_q  <= hist2_d;
         armed1_q <= armed1_d;
         armed2_q <= armed2_d;
         settle_q <= settle_d;
         a_q      <= a_d;
         b_q      <= b_d;
      end
   end

   assign a = a_q;
   assign b = b_q;

endmodule

// File: tb/tb_data_4.sv
// Bench for data_4: directed scenarios plus randomized strobes, checked every cycle
// against a model built from the per-edge strobe sample history.
module tb_data_4;

   localparam int S = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] datain;
   logic       clk1;
   logic       clk2;
   logic [3:0] a;
   logic [3:0] b;

   int checks = 0;
   int errors = 0;

   bit         q1[$];
   bit         q2[$];
   logic [3:0] exp_a;
   logic [3:0] exp_b;

   data_4 #(.WIDTH(4), .SYNC_STAGES(S)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .datain (datain),
      .clk1   (clk1),
      .clk2   (clk2),
      .a      (a),
      .b      (b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic model_reset();
      q1.delete();
      q2.delete();
      exp_a = 4'h0;
      exp_b = 4'h0;
   endtask

   // A load lands at edge k when the strobe was sampled low at edge k-S-1
   // (an edge after reset release) and high at edge k-S.
   task automatic step();
      int         k;
      bit         l1, l2;
      logic [3:0] na, nb;
      @(posedge clk);
      q1.push_back(clk1);
      q2.push_back(clk2);
      k  = q1.size();
      l1 = (k >= S + 2) && (q1[k-S-2] == 1'b0) && (q1[k-S-1] == 1'b1);
      l2 = (k >= S + 2) && (q2[k-S-2] == 1'b0) && (q2[k-S-1] == 1'b1);
      na = l1 ? datain : exp_a;
      nb = l2 ? exp_a  : exp_b;
      exp_a = na;
      exp_b = nb;
      #1;
      chk("a_model", a, exp_a);
      chk("b_model", b, exp_b);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse(input bit s1, input bit s2, input int hi);
      clk1 = s1;
      clk2 = s2;
      steps(hi);
      clk1 = 1'b0;
      clk2 = 1'b0;
      steps(S + 2);
   endtask

   initial begin
      rst_n  = 1'b0;
      datain = 4'h0;
      clk1   = 1'b0;
      clk2   = 1'b0;
      model_reset();

      // reset and idle
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a", a, 4'h0);
      chk("rst_b", b, 4'h0);
      rst_n = 1'b1;
      steps(10);
      chk("idle_a", a, 4'h0);
      chk("idle_b", b, 4'h0);

      // stage-A load latency
      datain = 4'b1101;
      clk1   = 1'b1;
      steps(S);
      chk("lat_a_before", a, 4'h0);
      step();
      chk("lat_a_after", a, 4'b1101);
      chk("lat_b_hold", b, 4'h0);
      steps(5 - S - 1);
      clk1 = 1'b0;
      steps(S + 2);

      // stage-B copy, new word, copy again
      pulse(1'b0, 1'b1, 5);
      chk("copy1_b", b, 4'b1101);
      datain = 4'b0010;
      pulse(1'b1, 1'b0, 5);
      chk("word2_a", a, 4'b0010);
      chk("word2_b", b, 4'b1101);
      pulse(1'b0, 1'b1, 5);
      chk("copy2_b", b, 4'b0010);

      // simultaneous strobes shift
      datain = 4'b0111;
      pulse(1'b1, 1'b1, 5);
      chk("simul_a", a, 4'b0111);
      chk("simul_b", b, 4'b0010);

      // held strobe: exactly one load
      datain = 4'b1001;
      clk1   = 1'b1;
      steps(S + 1);
      for (int i = 0; i < 50 - S - 1; i++) begin
         datain = 4'($urandom);
         step();
      end
      chk("held_a", a, 4'b1001);
      clk1 = 1'b0;
      steps(S + 2);

      // randomized strobe levels and data
      for (int seg = 0; seg < 60; seg++) begin
         int hold;
         clk1 = 1'($urandom_range(0, 1));
         clk2 = 1'($urandom_range(0, 1));
         hold = $urandom_range(1, 6);
         for (int i = 0; i < hold; i++) begin
            datain = 4'($urandom);
            step();
         end
      end
      clk1 = 1'b0;
      clk2 = 1'b0;
      steps(S + 2);

      // strobe held high across reset release
      clk1  = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("arm_rst_a", a, 4'h0);
      chk("arm_rst_b", b, 4'h0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      datain = 4'b0110;
      steps(10);
      chk("arm_held_a", a, 4'h0);
      clk1 = 1'b0;
      steps(5);
      chk("arm_low_a", a, 4'h0);
      datain = 4'b1010;
      clk1   = 1'b1;
      steps(S + 1);
      chk("arm_rerise_a", a, 4'b1010);
      clk1 = 1'b0;
      steps(S + 2);
      pulse(1'b0, 1'b1, 4);
      chk("arm_copy_b", b, 4'b1010);

      // reset while a load is in flight
      datain = 4'b1111;
      clk1   = 1'b1;
      step();
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_a", a, 4'h0);
      chk("midrst_b", b, 4'h0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      steps(8);
      chk("midrst_after_a", a, 4'h0);
      clk1 = 1'b0;
      steps(5);
      chk("midrst_end_a", a, 4'h0);
      chk("midrst_end_b", b, 4'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
